// File: rtl/median_pkg.sv
// Shared types and defaults for the median partition stage.
//   state_t : controller states of one quickselect stage
//   sel_t   : which partition a window resolves to after the pixel load
package median_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DECIDE,
        ST_CTRL,
        ST_EMIT,
        ST_RESULT
    } state_t;

    typedef enum logic [1:0] {
        KEEP_LT,
        KEEP_GT,
        HIT_EQ
    } sel_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_SIZE = 1024;

endpackage

// File: rtl/median_px_buffer.sv
// Window pixel store: simple dual-port RAM, one write port, one read port
// with a registered (1-cycle) read.
//   clock              : system clock
//   wr_en_i/addr/data  : write port
//   rd_en_i/rd_addr_i  : read request; rd_data_o updates the next cycle and
//                        holds its value while rd_en_i is low
module median_px_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/median_partition_stage.sv
// One quickselect stage of a streaming median filter.
// Pops a (pivot, size, mpos) token triple, loads `size` pixels, partitions
// them against the pivot and either reports the median on out_median or
// forwards the kept partition (original order) plus a new token triple.
//   in_px/in_pivot/in_size/in_mpos  : rd/empty input FIFOs
//   out_px/out_pivot/out_size/out_mpos/out_median : wr/full output FIFOs
//
// state     | meaning
// ST_IDLE   | wait for all three tokens, pop them atomically
// ST_LOAD   | store pixels, count lt/eq against the pivot
// ST_DECIDE | pick partition, compute next size/rank/pivot
// ST_CTRL   | write next token triple (held until all three can accept)
// ST_EMIT   | rescan buffer, stream kept pixels to out_px
// ST_RESULT | write resolved median
module median_partition_stage
    import median_pkg::*;
#(
    parameter int                DATA_W        = DEF_DATA_W,
    parameter int                MAX_SIZE      = DEF_MAX_SIZE,
    parameter int                SIZE_W        = $clog2(MAX_SIZE) + 1,
    parameter logic [DATA_W-1:0] DEFAULT_PIVOT = DATA_W'((2 ** (DATA_W - 1)) - 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_px,
    output logic              in_px_rd,
    input  logic              in_px_empty,
    input  logic [DATA_W-1:0] in_pivot,
    output logic              in_pivot_rd,
    input  logic              in_pivot_empty,
    input  logic [SIZE_W-1:0] in_size,
    output logic              in_size_rd,
    input  logic              in_size_empty,
    input  logic [SIZE_W-1:0] in_mpos,
    output logic              in_mpos_rd,
    input  logic              in_mpos_empty,
    output logic [DATA_W-1:0] out_px,
    output logic              out_px_wr,
    input  logic              out_px_full,
    output logic [DATA_W-1:0] out_pivot,
    output logic              out_pivot_wr,
    input  logic              out_pivot_full,
    output logic [SIZE_W-1:0] out_size,
    output logic              out_size_wr,
    input  logic              out_size_full,
    output logic [SIZE_W-1:0] out_mpos,
    output logic              out_mpos_wr,
    input  logic              out_mpos_full,
    output logic [DATA_W-1:0] out_median,
    output logic              out_median_wr,
    input  logic              out_median_full
);

    localparam int ADDR_W = $clog2(MAX_SIZE);
    localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

    state_t            state_q, state_d;
    sel_t              sel_q, sel_d;
    logic [DATA_W-1:0] pivot_q, pivot_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] mpos_q, mpos_d;
    logic [SIZE_W-1:0] idx_q, idx_d;
    logic [SIZE_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [SIZE_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [DATA_W-1:0] first_lt_q, first_lt_d;
    logic [DATA_W-1:0] first_gt_q, first_gt_d;
    logic              seen_lt_q, seen_lt_d;
    logic              seen_gt_q, seen_gt_d;
    logic [DATA_W-1:0] new_pivot_q, new_pivot_d;
    logic [SIZE_W-1:0] new_size_q, new_size_d;
    logic [SIZE_W-1:0] new_mpos_q, new_mpos_d;
    logic [DATA_W-1:0] median_q, median_d;
    logic [SIZE_W-1:0] rd_idx_q, rd_idx_d;
    logic [SIZE_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              rvld_q, rvld_d;
    logic [DATA_W-1:0] out_px_q, out_px_d;
    logic              out_px_wr_q, out_px_wr_d;

    logic              tok_pop, px_acc, px_xfer, keep_px;
    logic [SIZE_W-1:0] size_clamp, mpos_clamp, lt_eq;
    sel_t              dec_sel;
    logic [SIZE_W-1:0] dec_size, dec_mpos;
    logic [DATA_W-1:0] dec_pivot;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data;

    median_px_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_SIZE),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clock     (clock),
        .wr_en_i   (px_acc),
        .wr_addr_i (idx_q[ADDR_W-1:0]),
        .wr_data_i (in_px),
        .rd_en_i   (buf_rd_en),
        .rd_addr_i (buf_rd_addr),
        .rd_data_o (buf_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= KEEP_LT;
            pivot_q     <= DEFAULT_PIVOT;
            size_q      <= '0;
            mpos_q      <= '0;
            idx_q       <= '0;
            lt_cnt_q    <= '0;
            eq_cnt_q    <= '0;
            first_lt_q  <= '0;
            first_gt_q  <= '0;
            seen_lt_q   <= 1'b0;
            seen_gt_q   <= 1'b0;
            new_pivot_q <= '0;
            new_size_q  <= '0;
            new_mpos_q  <= '0;
            median_q    <= '0;
            rd_idx_q    <= '0;
            wr_cnt_q    <= '0;
            rvld_q      <= 1'b0;
            out_px_q    <= '0;
            out_px_wr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pivot_q     <= pivot_d;
            size_q      <= size_d;
            mpos_q      <= mpos_d;
            idx_q       <= idx_d;
            lt_cnt_q    <= lt_cnt_d;
            eq_cnt_q    <= eq_cnt_d;
            first_lt_q  <= first_lt_d;
            first_gt_q  <= first_gt_d;
            seen_lt_q   <= seen_lt_d;
            seen_gt_q   <= seen_gt_d;
            new_pivot_q <= new_pivot_d;
            new_size_q  <= new_size_d;
            new_mpos_q  <= new_mpos_d;
            median_q    <= median_d;
            rd_idx_q    <= rd_idx_d;
            wr_cnt_q    <= wr_cnt_d;
            rvld_q      <= rvld_d;
            out_px_q    <= out_px_d;
            out_px_wr_q <= out_px_wr_d;
        end
    end

    always_comb begin
        tok_pop    = (state_q == ST_IDLE) && !in_pivot_empty && !in_size_empty && !in_mpos_empty;
        px_acc     = (state_q == ST_LOAD) && !in_px_empty;
        size_clamp = (in_size > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE) : in_size;
        mpos_clamp = (in_mpos >= size_clamp) ? size_clamp - ONE : in_mpos;
        lt_eq      = lt_cnt_q + eq_cnt_q;
        px_xfer    = out_px_wr_q && !out_px_full;
        keep_px    = (sel_q == KEEP_LT) ? (buf_rd_data < pivot_q) : (buf_rd_data > pivot_q);

        // The first LT and first GT pixels are captured during the load, so
        // the next pivot (first kept element) is known without a buffer scan.
        if (mpos_q < lt_cnt_q) begin
            dec_sel   = KEEP_LT;
            dec_size  = lt_cnt_q;
            dec_mpos  = mpos_q;
            dec_pivot = first_lt_q;
        end else if (mpos_q < lt_eq) begin
            dec_sel   = HIT_EQ;
            dec_size  = '0;
            dec_mpos  = '0;
            dec_pivot = pivot_q;
        end else begin
            dec_sel   = KEEP_GT;
            dec_size  = size_q - lt_eq;
            dec_mpos  = mpos_q - lt_eq;
            dec_pivot = first_gt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pivot_d     = pivot_q;
        size_d      = size_q;
        mpos_d      = mpos_q;
        idx_d       = idx_q;
        lt_cnt_d    = lt_cnt_q;
        eq_cnt_d    = eq_cnt_q;
        first_lt_d  = first_lt_q;
        first_gt_d  = first_gt_q;
        seen_lt_d   = seen_lt_q;
        seen_gt_d   = seen_gt_q;
        new_pivot_d = new_pivot_q;
        new_size_d  = new_size_q;
        new_mpos_d  = new_mpos_q;
        median_d    = median_q;
        rd_idx_d    = rd_idx_q;
        wr_cnt_d    = wr_cnt_q;
        rvld_d      = rvld_q;
        out_px_d    = out_px_q;
        out_px_wr_d = out_px_wr_q;
        buf_rd_en   = 1'b0;
        buf_rd_addr = '0;

        case (state_q)
            ST_IDLE: begin
                if (tok_pop) begin
                    pivot_d   = in_pivot;
                    size_d    = size_clamp;
                    mpos_d    = mpos_clamp;
                    idx_d     = '0;
                    lt_cnt_d  = '0;
                    eq_cnt_d  = '0;
                    seen_lt_d = 1'b0;
                    seen_gt_d = 1'b0;
                    if (size_clamp != '0) state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (px_acc) begin
                    idx_d = idx_q + ONE;
                    if (in_px < pivot_q) begin
                        lt_cnt_d = lt_cnt_q + ONE;
                        if (!seen_lt_q) begin
                            first_lt_d = in_px;
                            seen_lt_d  = 1'b1;
                        end
                    end else if (in_px == pivot_q) begin
                        eq_cnt_d = eq_cnt_q + ONE;
                    end else if (!seen_gt_q) begin
                        first_gt_d = in_px;
                        seen_gt_d  = 1'b1;
                    end
                    if (idx_q == size_q - ONE) state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                sel_d       = dec_sel;
                new_size_d  = dec_size;
                new_mpos_d  = dec_mpos;
                new_pivot_d = dec_pivot;
                median_d    = dec_pivot;
                if (dec_sel == HIT_EQ || dec_size == ONE) state_d = ST_RESULT;
                else                                       state_d = ST_CTRL;
            end
            ST_CTRL: begin
                // Prefetch buffer[0] so EMIT starts with valid read data.
                buf_rd_en = 1'b1;
                if (!out_pivot_full && !out_size_full && !out_mpos_full) begin
                    state_d     = ST_EMIT;
                    rd_idx_d    = ONE;
                    rvld_d      = 1'b1;
                    wr_cnt_d    = '0;
                    out_px_wr_d = 1'b0;
                end
            end
            ST_EMIT: begin
                if (px_xfer) wr_cnt_d = wr_cnt_q + ONE;
                if (px_xfer && wr_cnt_q == new_size_q - ONE) begin
                    state_d     = ST_IDLE;
                    out_px_wr_d = 1'b0;
                    rvld_d      = 1'b0;
                end else if (!out_px_full) begin
                    // Whole read pipe advances only when out_px can accept;
                    // otherwise the RAM output register holds its word.
                    out_px_wr_d = rvld_q && keep_px;
                    if (rvld_q && keep_px) out_px_d = buf_rd_data;
                    if (rd_idx_q < size_q) begin
                        buf_rd_en   = 1'b1;
                        buf_rd_addr = rd_idx_q[ADDR_W-1:0];
                        rd_idx_d    = rd_idx_q + ONE;
                        rvld_d      = 1'b1;
                    end else begin
                        rvld_d = 1'b0;
                    end
                end
            end
            ST_RESULT: begin
                if (!out_median_full) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_pivot_rd   = !reset && tok_pop;
        in_size_rd    = !reset && tok_pop;
        in_mpos_rd    = !reset && tok_pop;
        in_px_rd      = !reset && px_acc;
        out_pivot_wr  = !reset && (state_q == ST_CTRL);
        out_size_wr   = !reset && (state_q == ST_CTRL);
        out_mpos_wr   = !reset && (state_q == ST_CTRL);
        out_median_wr = !reset && (state_q == ST_RESULT);
        out_px_wr     = !reset && out_px_wr_q;
        out_px        = out_px_q;
        out_pivot     = new_pivot_q;
        out_size      = new_size_q;
        out_mpos      = new_mpos_q;
        out_median    = median_q;
    end

endmodule

// File: doc/median_partition_stage.md
Name: median_partition_stage

Overview:
- One quickselect stage of the streaming median filter, generalised in pixel width and buffer depth.
- Accepts one control token triple (pivot, size, median position), then `size` pixels. It partitions the pixels against the pivot and decides which partition holds the median.
- If the median is resolved, it emits it on a dedicated result channel. Otherwise it forwards the kept partition, in original order, with updated pivot, size and median position to the next stage.
- Stages chain FIFO-to-FIFO; every channel uses rd/empty (input) or wr/full (output) handshakes.

Parameters:
- DATA_W, 8, pixel width in bits.
- MAX_SIZE, 1024, maximum pixels per window (internal buffer depth).
- SIZE_W, $clog2(MAX_SIZE)+1, width of the size and position fields.
- DEFAULT_PIVOT, 2**(DATA_W-1)-1, pivot register value after reset.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_px / in_px_rd / in_px_empty  in/out/in  DATA_W/1/1  pixel stream.
- in_pivot / in_pivot_rd / in_pivot_empty  in/out/in  DATA_W/1/1  pivot token.
- in_size / in_size_rd / in_size_empty  in/out/in  SIZE_W/1/1  window size token.
- in_mpos / in_mpos_rd / in_mpos_empty  in/out/in  SIZE_W/1/1  0-based median rank token.
- out_px / out_px_wr / out_px_full  out/out/in  DATA_W/1/1  kept-partition pixels.
- out_pivot / out_pivot_wr / out_pivot_full  out/out/in  DATA_W/1/1  next pivot.
- out_size / out_size_wr / out_size_full  out/out/in  SIZE_W/1/1  next size.
- out_mpos / out_mpos_wr / out_mpos_full  out/out/in  SIZE_W/1/1  next rank.
- out_median / out_median_wr / out_median_full  out/out/in  DATA_W/1/1  resolved median.

Behaviour:
- Reset (asynchronous, active-high):
  - State to IDLE; counters to 0; pivot register to DEFAULT_PIVOT.
  - All *_wr and *_rd outputs low while reset is asserted; all data outputs 0.
  - Reset mid-operation abandons the window: no partial outputs, buffer contents are don't-care.
- Transfer rule: a transfer occurs on a cycle where rd=1 and empty=0, or wr=1 and full=0. No output's wr or data changes while its full is high.
- IDLE:
  - in_pivot_rd, in_size_rd and in_mpos_rd are all asserted in the same cycle, and only when all three empties are low. This is an atomic token pop.
  - Latch the tokens. size is clamped to MAX_SIZE; mpos is clamped to size-1.
  - size==0 stays in IDLE with no output.
  - Otherwise go to LOAD with idx=0, lt_cnt=0, eq_cnt=0.
- LOAD:
  - in_px_rd = ~in_px_empty. Each accepted pixel is written to buffer[idx] and idx increments.
  - lt_cnt increments when px<pivot; eq_cnt increments when px==pivot (unsigned compare).
  - The cycle accepting pixel size-1 moves to DECIDE. Empty gaps stall without penalty.
- DECIDE (1 cycle):
  - mpos < lt_cnt: keep LT; new_size=lt_cnt; new_mpos=mpos.
  - mpos < lt_cnt+eq_cnt: median=pivot; go to RESULT.
  - Otherwise keep GT; new_size=size-lt_cnt-eq_cnt; new_mpos=mpos-lt_cnt-eq_cnt.
  - new_size==1 means the single kept element is the median: scan the buffer for it, then go to RESULT.
  - Otherwise go to CTRL.
- CTRL:
  - out_pivot_wr, out_size_wr and out_mpos_wr are asserted together once, held until all three fulls are low in the same cycle.
  - new pivot = first buffer element (lowest index) belonging to the kept partition, found by a scan during DECIDE/CTRL.
  - Then go to EMIT.
- EMIT:
  - Scan idx 0..size-1 through the synchronous-read buffer (1-cycle read latency).
  - Write kept-partition elements to out_px in index order; exactly new_size writes.
  - out_px_full stalls the scan without dropping or duplicating data.
  - After the last write, return to IDLE.
- RESULT: out_median_wr held until out_median_full is low, then return to IDLE.
- No new tokens are popped before the current window completes.
- Throughput: one pixel per cycle in LOAD and EMIT with no backpressure.
- Latency from the last input pixel to the first out_px is at most 4 cycles plus the pivot-scan length.

Decomposition:
- Package median_pkg holds:
  - the state encoding (IDLE, LOAD, DECIDE, CTRL, EMIT, RESULT);
  - the partition select encoding (KEEP_LT, KEEP_GT, HIT_EQ);
  - default constants.
- Sub-module median_px_buffer: simple dual-port RAM, MAX_SIZE x DATA_W, one write port and one synchronous read port.

Test Plan:
- Pixels 5,1,9,3,7,2,8,4; pivot 5; size 8; mpos 4 -> lt=4, eq=1 -> out_median=5 once, no out_px/ctrl writes.
- Same pixels; pivot 3; mpos 4 -> keep GT -> ctrl writes pivot 5, size 5, mpos 1; out_px 5,9,7,8,4 in order.
- Same as the previous case with out_px_full toggling every other cycle and out_size_full held 3 cycles -> identical sequence, ctrl triple written once, no loss or duplication.
- Size 1, pixel 200, pivot 127, mpos 0 -> out_median=200; size 0 token -> no outputs, stage returns to IDLE.
- in_px_empty random gaps, pivot token arriving 5 cycles after size/mpos -> no pop until all three present; results match the no-gap run.
- Reset asserted mid-LOAD after 3 pixels -> all wr/rd low immediately; after release, a fresh 8-pixel window is processed correctly.
